// File: rtl/intrapred_pipectl_if.sv
// Handshake and tag bus between the intra-prediction pipeline controller and its stages/consumer.
// The master drives frame control, stage completions and consumer ready; the slave is the controller.
interface intrapred_pipectl_if #(
  parameter int unsigned NUM_STAGES     = 5,
  parameter int unsigned MB_NUMBER_BITS = 12
);
  localparam int unsigned MW = MB_NUMBER_BITS + 1;

  logic                     start;
  logic                     enable;
  logic [MW-1:0]            frame_mbs;
  logic [NUM_STAGES-1:0]    stage_done;
  logic                     out_ready;

  logic [NUM_STAGES-1:0]    stage_en;
  logic [NUM_STAGES*MW-1:0] stage_mbnumber;
  logic [NUM_STAGES-1:0]    stage_valid;
  logic                     out_valid;
  logic [MW-1:0]            out_mbnumber;
  logic                     busy;
  logic                     frame_done;

  modport master (
    output start, enable, frame_mbs, stage_done, out_ready,
    input  stage_en, stage_mbnumber, stage_valid, out_valid, out_mbnumber, busy, frame_done
  );

  modport slave (
    input  start, enable, frame_mbs, stage_done, out_ready,
    output stage_en, stage_mbnumber, stage_valid, out_valid, out_mbnumber, busy, frame_done
  );
endinterface

// File: rtl/intrapred_pipectl.sv
// Elastic slot pipeline controller for intra prediction: issues mbnumbers across a frame,
// tracks one macroblock per stage slot with a done handshake, and retires them in order.
module intrapred_pipectl #(
  parameter int unsigned NUM_STAGES     = 5,
  parameter int unsigned MB_NUMBER_BITS = 12
) (
  input  logic               clk,
  input  logic               reset,
  intrapred_pipectl_if.slave bus
);
  localparam int unsigned MW   = MB_NUMBER_BITS + 1;
  localparam int unsigned LAST = NUM_STAGES - 1;

  typedef enum logic [1:0] {FSM_IDLE, FSM_RUN, FSM_DRAIN} fsm_e;
  typedef enum logic [1:0] {SLOT_EMPTY, SLOT_BUSY, SLOT_HELD} slot_e;

  fsm_e                  state_q, state_nxt;
  slot_e                 slot_q   [NUM_STAGES];
  slot_e                 slot_nxt [NUM_STAGES];
  logic [MW-1:0]         mb_q     [NUM_STAGES];
  logic [MW-1:0]         mb_nxt   [NUM_STAGES];
  logic [MW-1:0]         mb_src   [NUM_STAGES];

  logic [MW-1:0]         frame_q, frame_nxt;
  logic [MW-1:0]         issue_cnt_q, issue_cnt_nxt;
  logic [MW-1:0]         retire_cnt_q, retire_cnt_nxt;

  logic [NUM_STAGES-1:0] en_q, en_nxt;
  logic [NUM_STAGES-1:0] valid_q, valid_nxt;
  logic                  out_valid_q, out_valid_nxt;
  logic [MW-1:0]         out_mb_q;
  logic                  busy_q, busy_nxt;
  logic                  frame_done_q, frame_done_nxt;

  logic [NUM_STAGES-1:0] leave;
  logic [NUM_STAGES-1:0] enter;
  logic                  issue;
  logic                  retire;

  // Slot moves: resolved from the last slot downward so a full pipeline shifts in one cycle.
  always_comb begin
    leave       = '0;
    enter       = '0;
    retire      = (slot_q[LAST] == SLOT_HELD) && bus.out_ready;
    leave[LAST] = retire;
    for (int i = int'(NUM_STAGES) - 2; i >= 0; i--) begin
      leave[i] = bus.enable && (slot_q[i] == SLOT_HELD) &&
                 ((slot_q[i+1] == SLOT_EMPTY) || leave[i+1]);
    end
    issue = (state_q == FSM_RUN) && bus.enable && (issue_cnt_q < frame_q) &&
            ((slot_q[0] == SLOT_EMPTY) || leave[0]);
    enter[0]  = issue;
    mb_src[0] = issue_cnt_q;
    for (int i = 1; i < int'(NUM_STAGES); i++) begin
      enter[i]  = leave[i-1];
      mb_src[i] = mb_q[i-1];
    end
  end

  // Per-slot next state; done is only honoured while BUSY.
  always_comb begin
    en_nxt    = '0;
    valid_nxt = '0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      slot_nxt[i] = slot_q[i];
      mb_nxt[i]   = mb_q[i];
      if (enter[i]) begin
        slot_nxt[i] = SLOT_BUSY;
        mb_nxt[i]   = mb_src[i];
        en_nxt[i]   = 1'b1;
      end else if (leave[i]) begin
        slot_nxt[i] = SLOT_EMPTY;
      end else if ((slot_q[i] == SLOT_BUSY) && bus.stage_done[i]) begin
        slot_nxt[i] = SLOT_HELD;
      end
      valid_nxt[i] = (slot_nxt[i] != SLOT_EMPTY);
    end
    out_valid_nxt = (slot_nxt[LAST] == SLOT_HELD);
  end

  // Frame FSM and saturating issue/retire counters.
  always_comb begin
    state_nxt      = state_q;
    frame_nxt      = frame_q;
    issue_cnt_nxt  = issue_cnt_q;
    retire_cnt_nxt = retire_cnt_q;
    frame_done_nxt = 1'b0;
    if (issue && (issue_cnt_q < frame_q)) begin
      issue_cnt_nxt = issue_cnt_q + MW'(1);
    end
    if (retire && (retire_cnt_q < frame_q)) begin
      retire_cnt_nxt = retire_cnt_q + MW'(1);
    end
    unique case (state_q)
      FSM_IDLE: begin
        if (bus.start) begin
          frame_nxt      = bus.frame_mbs;
          issue_cnt_nxt  = '0;
          retire_cnt_nxt = '0;
          if (bus.frame_mbs == '0) begin
            frame_done_nxt = 1'b1;
          end else begin
            state_nxt = FSM_RUN;
          end
        end
      end
      FSM_RUN: begin
        if (issue && ((issue_cnt_q + MW'(1)) == frame_q)) begin
          state_nxt = FSM_DRAIN;
        end
      end
      FSM_DRAIN: begin
        if (retire_cnt_q == frame_q) begin
          state_nxt      = FSM_IDLE;
          frame_done_nxt = 1'b1;
        end
      end
      default: state_nxt = FSM_IDLE;
    endcase
    busy_nxt = (state_nxt != FSM_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FSM_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_STAGES); i++) begin
        slot_q[i] <= SLOT_EMPTY;
        mb_q[i]   <= '0;
      end
      frame_q      <= '0;
      issue_cnt_q  <= '0;
      retire_cnt_q <= '0;
      en_q         <= '0;
      valid_q      <= '0;
      out_valid_q  <= 1'b0;
      out_mb_q     <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_STAGES); i++) begin
        slot_q[i] <= slot_nxt[i];
        mb_q[i]   <= mb_nxt[i];
      end
      frame_q      <= frame_nxt;
      issue_cnt_q  <= issue_cnt_nxt;
      retire_cnt_q <= retire_cnt_nxt;
      en_q         <= en_nxt;
      valid_q      <= valid_nxt;
      out_valid_q  <= out_valid_nxt;
      out_mb_q     <= mb_nxt[LAST];
      busy_q       <= busy_nxt;
      frame_done_q <= frame_done_nxt;
    end
  end

  for (genvar g = 0; g < int'(NUM_STAGES); g++) begin : g_mb_out
    assign bus.stage_mbnumber[g*MW +: MW] = mb_q[g];
  end

  assign bus.stage_en     = en_q;
  assign bus.stage_valid  = valid_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_mbnumber = out_mb_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = frame_done_q;

endmodule

// File: tb/tb_intrapred_pipectl.sv
// Directed bench for intrapred_pipectl: five stages, hand-computed cycle expectations and
// an in-order retire scoreboard per frame.
module tb_intrapred_pipectl;
  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  intrapred_pipectl_if #(.NUM_STAGES(5), .MB_NUMBER_BITS(12)) ifc ();

  intrapred_pipectl #(.NUM_STAGES(5), .MB_NUMBER_BITS(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] mbn(input int i);
    return ifc.stage_mbnumber[i*13 +: 13];
  endfunction

  task automatic start_frame(input logic [12:0] n);
    ifc.frame_mbs = n;
    ifc.start     = 1'b1;
    step();
    ifc.start     = 1'b0;
  endtask

  // Follow a frame to frame_done, checking retire order 0..n-1 and a single done pulse.
  task automatic run_until_done(input string tag, input int n, input int budget);
    int got = 0;
    int c   = 0;
    while (!ifc.frame_done && c < budget) begin
      if (ifc.out_valid && ifc.out_ready) begin
        check({tag, "_order"}, 64'(ifc.out_mbnumber), 64'(got));
        got++;
      end
      step();
      c++;
    end
    check({tag, "_done_seen"}, 64'(ifc.frame_done), 64'(1));
    check({tag, "_busy_at_done"}, 64'(ifc.busy), 64'(0));
    check({tag, "_retired"}, 64'(got), 64'(n));
    for (int k = 0; k < 3; k++) begin
      step();
      check({tag, "_done_once"}, 64'(ifc.frame_done), 64'(0));
      check({tag, "_idle_empty"}, 64'(ifc.stage_valid), 64'(0));
    end
  endtask

  initial begin
    reset          = 1'b0;
    ifc.start      = 1'b0;
    ifc.enable     = 1'b1;
    ifc.frame_mbs  = '0;
    ifc.stage_done = 5'b11111;
    ifc.out_ready  = 1'b1;

    // Reset state
    step();
    check("rst_valid", 64'(ifc.stage_valid), 64'(0));
    check("rst_en", 64'(ifc.stage_en), 64'(0));
    check("rst_busy", 64'(ifc.busy), 64'(0));
    check("rst_out_valid", 64'(ifc.out_valid), 64'(0));
    check("rst_frame_done", 64'(ifc.frame_done), 64'(0));
    reset = 1'b1;
    step();

    // Frame of 4, all done immediate: issue every 2 cycles, retire 10,12,14,16, done at 18
    start_frame(13'd4);
    check("t1_busy_c0", 64'(ifc.busy), 64'(1));
    for (int c = 1; c <= 20; c++) begin
      step();
      check("t1_en0", 64'(ifc.stage_en[0]), 64'((c % 2 == 1) && (c <= 7)));
      if ((c % 2 == 1) && (c <= 7)) check("t1_mb0", 64'(mbn(0)), 64'((c - 1) / 2));
      check("t1_out_valid", 64'(ifc.out_valid), 64'((c % 2 == 0) && (c >= 10) && (c <= 16)));
      if ((c % 2 == 0) && (c >= 10) && (c <= 16))
        check("t1_out_mb", 64'(ifc.out_mbnumber), 64'((c - 10) / 2));
      check("t1_frame_done", 64'(ifc.frame_done), 64'(c == 18));
      check("t1_busy", 64'(ifc.busy), 64'(c < 18));
    end

    // Stage 2 stalls on mbnumber 0 until cycle 10
    ifc.stage_done = 5'b11011;
    start_frame(13'd4);
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c >= 6 && c <= 11) begin
        check("t2_valid_held", 64'(ifc.stage_valid), 64'(5'b00111));
        check("t2_no_en", 64'(ifc.stage_en), 64'(0));
      end
      if (c == 12) begin
        check("t2_en_shift", 64'(ifc.stage_en), 64'(5'b01111));
        check("t2_mb0", 64'(mbn(0)), 64'(3));
        check("t2_mb1", 64'(mbn(1)), 64'(2));
        check("t2_mb2", 64'(mbn(2)), 64'(1));
        check("t2_mb3", 64'(mbn(3)), 64'(0));
      end
      if (c == 10) ifc.stage_done = 5'b11111;
    end
    run_until_done("t2", 4, 60);

    // Consumer back-pressure fills every slot
    ifc.out_ready = 1'b0;
    start_frame(13'd8);
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c >= 10) begin
        check("t3_full", 64'(ifc.stage_valid), 64'(5'b11111));
        check("t3_out_valid", 64'(ifc.out_valid), 64'(1));
        check("t3_out_mb", 64'(ifc.out_mbnumber), 64'(0));
        check("t3_no_issue", 64'(ifc.stage_en), 64'(0));
      end
    end
    ifc.out_ready = 1'b1;
    run_until_done("t3", 8, 120);

    // Pause for 5 cycles with two macroblocks in flight
    start_frame(13'd6);
    for (int c = 1; c <= 3; c++) step();
    check("t4_en_c3", 64'(ifc.stage_en), 64'(5'b00011));
    ifc.enable = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      step();
      check("t4_pause_en", 64'(ifc.stage_en), 64'(0));
      check("t4_pause_valid", 64'(ifc.stage_valid), 64'(5'b00011));
    end
    ifc.enable = 1'b1;
    step();
    check("t4_resume_en", 64'(ifc.stage_en), 64'(5'b00111));
    check("t4_resume_mb0", 64'(mbn(0)), 64'(2));
    check("t4_resume_mb1", 64'(mbn(1)), 64'(1));
    check("t4_resume_mb2", 64'(mbn(2)), 64'(0));
    run_until_done("t4", 6, 80);

    // Empty frame
    start_frame(13'd0);
    check("t5_done_c0", 64'(ifc.frame_done), 64'(1));
    check("t5_busy_c0", 64'(ifc.busy), 64'(0));
    for (int c = 1; c <= 5; c++) begin
      step();
      check("t5_done_once", 64'(ifc.frame_done), 64'(0));
      check("t5_no_en", 64'(ifc.stage_en), 64'(0));
      check("t5_busy", 64'(ifc.busy), 64'(0));
    end

    // Asynchronous reset with three in flight, then a fresh frame
    start_frame(13'd8);
    for (int c = 1; c <= 5; c++) step();
    check("t6_inflight", 64'(ifc.stage_valid), 64'(5'b00111));
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 64'(ifc.stage_valid), 64'(0));
    check("t6_rst_en", 64'(ifc.stage_en), 64'(0));
    check("t6_rst_busy", 64'(ifc.busy), 64'(0));
    check("t6_rst_mb", 64'(|ifc.stage_mbnumber), 64'(0));
    check("t6_rst_out", 64'(ifc.out_valid), 64'(0));
    step();
    step();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("t6_no_done", 64'(ifc.frame_done), 64'(0));
      check("t6_idle", 64'(ifc.busy), 64'(0));
    end
    start_frame(13'd2);
    step();
    check("t6_restart_en", 64'(ifc.stage_en), 64'(5'b00001));
    check("t6_restart_mb", 64'(mbn(0)), 64'(0));
    run_until_done("t6", 2, 40);

    // Stray done on empty slot 3, and start while busy
    ifc.stage_done = 5'b01000;
    for (int c = 0; c < 3; c++) step();
    check("t7_idle_stray", 64'(ifc.stage_valid), 64'(0));
    ifc.stage_done = 5'b11111;
    start_frame(13'd3);
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c >= 3) check("t7_no_out", 64'(ifc.out_valid), 64'(0));
      if (c == 7) check("t7_en_c7", 64'(ifc.stage_en), 64'(5'b01110));
      if (c == 9) check("t7_valid_c9", 64'(ifc.stage_valid), 64'(5'b01110));
      if (c == 2) ifc.stage_done = 5'b10111;
      if (c == 4) begin
        ifc.frame_mbs = 13'd9;
        ifc.start     = 1'b1;
      end
      if (c == 5) ifc.start = 1'b0;
    end
    ifc.stage_done = 5'b11111;
    run_until_done("t7", 3, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
